// File: rtl/mul_pipe_param_if.sv
// -----------------------------------------------------------------------------
// mul_pipe_param_if
// Handshake bundle for the pipelined multiplier.
//   Input side : in_valid, in_ready, in_signed, mul_a, mul_b, in_tag
//   Output side: out_valid, out_ready, mul_out, out_tag
// Modports:
//   master - the block feeding operands and consuming results
//   slave  - the multiplier itself
// -----------------------------------------------------------------------------
interface mul_pipe_param_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   mul_out;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_signed, mul_a, mul_b, in_tag, out_ready,
    input  in_ready, out_valid, mul_out, out_tag
  );

  modport slave (
    input  in_valid, in_signed, mul_a, mul_b, in_tag, out_ready,
    output in_ready, out_valid, mul_out, out_tag
  );
endinterface

// File: rtl/mul_pipe_param.sv
// -----------------------------------------------------------------------------
// mul_pipe_param
// Fully pipelined WIDTH x WIDTH integer multiplier with per-operation
// signed/unsigned mode, valid/ready handshake with whole-pipeline stall and a
// sideband tag returned in order with each product.
//
// Parameters:
//   WIDTH - operand width, power of two from 4 to 32
//   TAG_W - sideband tag width
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mul_pipe_param_if.slave: in_valid/in_ready/in_signed/mul_a/mul_b/
//           in_tag on the input side, out_valid/out_ready/mul_out/out_tag on
//           the output side
//
// Structure:
//   Stage 0 registers WIDTH partial products, each 2*WIDTH bits wide. The
//   reduction tree then adds adjacent pairs, one level per stage, so the
//   latency is 1 + log2(WIDTH) and the critical path is one 2*WIDTH-bit adder.
//   All tree nodes live in one flat array: level k starts at index
//   2*WIDTH - 2*(WIDTH >> k), and the final node (index 2*WIDTH-2) is the
//   output register.
//   The whole pipeline advances together on adv = !out_valid || out_ready;
//   bubbles are carried, not compressed.
// -----------------------------------------------------------------------------
module mul_pipe_param #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_pipe_param_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int LOGW  = $clog2(WIDTH);
  localparam int NODES = 2 * WIDTH - 1;

  logic              adv_s;
  logic [PW-1:0]     a_ext_s;
  logic [PW-1:0]     pp_s [WIDTH-1];
  logic [PW-1:0]     pp_top_s;
  logic              neg_s;
  logic [PW-1:0]     sum_s [WIDTH-1];

  logic [PW-1:0]     node_r [NODES];
  logic              neg_r;
  logic              valid_r [LOGW+1];
  logic [TAG_W-1:0]  tag_r [LOGW+1];

  // The pipeline moves as one unit; input acceptance depends only on the
  // output side, never on in_valid.
  assign adv_s        = !valid_r[LOGW] || bus.out_ready;
  assign bus.in_ready = adv_s;

  assign bus.out_valid = valid_r[LOGW];
  assign bus.mul_out   = node_r[NODES-1];
  assign bus.out_tag   = tag_r[LOGW];

  // Multiplicand extended to product width according to the operation mode.
  always_comb begin
    if (bus.in_signed) begin
      a_ext_s = {{WIDTH{bus.mul_a[WIDTH-1]}}, bus.mul_a};
    end else begin
      a_ext_s = {{WIDTH{1'b0}}, bus.mul_a};
    end
  end

  // Rows 0..WIDTH-2 are plain shifted copies of the multiplicand. Operands are
  // gated by in_valid so bubbles carry zeros and mul_out stays 0 after reset
  // until the first real result arrives.
  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_pp
    assign pp_s[i] = (bus.in_valid && bus.mul_b[i]) ? (a_ext_s << i) : {PW{1'b0}};
  end

  // Top row: in signed mode mul_b[WIDTH-1] weighs -2^(WIDTH-1), so this row is
  // negated. Only the bit inversion happens here; the +1 of the two's
  // complement is carried in neg_r and enters as the carry-in of the level-1
  // adder that consumes this row, keeping stage 0 free of adders.
  always_comb begin
    if (bus.in_valid && bus.mul_b[WIDTH-1] && bus.in_signed) begin
      pp_top_s = ~(a_ext_s << (WIDTH - 1));
      neg_s    = 1'b1;
    end else if (bus.in_valid && bus.mul_b[WIDTH-1]) begin
      pp_top_s = a_ext_s << (WIDTH - 1);
      neg_s    = 1'b0;
    end else begin
      pp_top_s = {PW{1'b0}};
      neg_s    = 1'b0;
    end
  end

  // Reduction tree: every node of level k is the sum of an adjacent pair of
  // level k-1, modulo 2^PW. The pair holding the top row also absorbs neg_r.
  for (genvar k = 1; k <= LOGW; k++) begin : g_lvl
    for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_pair
      localparam int SRC  = 2 * WIDTH - 2 * (WIDTH >> (k - 1)) + 2 * j;
      localparam int DST  = 2 * WIDTH - 2 * (WIDTH >> k) + j;
      localparam bit LAST = (k == 1) && (j == (WIDTH / 2) - 1);
      assign sum_s[DST-WIDTH] = node_r[SRC] + node_r[SRC+1]
                                + {{(PW-1){1'b0}}, (neg_r & LAST)};
    end
  end

  // Pipeline registers: data, carry-in, valid and tag all advance together on
  // adv and hold together otherwise. Reset clears everything, discarding any
  // results in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NODES; n++) begin
        node_r[n] <= {PW{1'b0}};
      end
      neg_r <= 1'b0;
      for (int k = 0; k <= LOGW; k++) begin
        valid_r[k] <= 1'b0;
        tag_r[k]   <= {TAG_W{1'b0}};
      end
    end else if (adv_s) begin
      for (int i = 0; i < WIDTH - 1; i++) begin
        node_r[i] <= pp_s[i];
      end
      node_r[WIDTH-1] <= pp_top_s;
      for (int n = WIDTH; n < NODES; n++) begin
        node_r[n] <= sum_s[n-WIDTH];
      end
      neg_r <= neg_s;
      // adv equals in_ready, so in_valid alone marks an input transfer here.
      valid_r[0] <= bus.in_valid;
      if (bus.in_valid) begin
        tag_r[0] <= bus.in_tag;
      end else begin
        tag_r[0] <= {TAG_W{1'b0}};
      end
      for (int k = 1; k <= LOGW; k++) begin
        valid_r[k] <= valid_r[k-1];
        tag_r[k]   <= tag_r[k-1];
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe_param.sv
// -----------------------------------------------------------------------------
// tb_mul_pipe_param
// Three multiplier instances (WIDTH 4, 8, 32) driven from one stimulus block.
// Expected products are pushed into a scoreboard queue when an input transfer
// is seen; a monitor pops and compares whenever an instance presents a result.
// The reference product is plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_mul_pipe_param;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle counter used to time each result from acceptance to presentation.
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] a_v    [ND];
  logic [31:0] b_v    [ND];
  logic        sg_v   [ND];
  logic        vld_v  [ND];
  logic        ordy_v [ND];
  logic [3:0]  tag_v  [ND];

  logic        ov_w [ND];
  logic        ir_w [ND];
  logic [63:0] mo_w [ND];
  logic [3:0]  ot_w [ND];

  mul_pipe_param_if #(.WIDTH(4),  .TAG_W(4)) if4  ();
  mul_pipe_param_if #(.WIDTH(8),  .TAG_W(4)) if8  ();
  mul_pipe_param_if #(.WIDTH(32), .TAG_W(4)) if32 ();

  assign if4.in_valid  = vld_v[0];
  assign if4.in_signed = sg_v[0];
  assign if4.mul_a     = a_v[0][3:0];
  assign if4.mul_b     = b_v[0][3:0];
  assign if4.in_tag    = tag_v[0];
  assign if4.out_ready = ordy_v[0];
  assign ov_w[0]       = if4.out_valid;
  assign ir_w[0]       = if4.in_ready;
  assign mo_w[0]       = {56'd0, if4.mul_out};
  assign ot_w[0]       = if4.out_tag;

  assign if8.in_valid  = vld_v[1];
  assign if8.in_signed = sg_v[1];
  assign if8.mul_a     = a_v[1][7:0];
  assign if8.mul_b     = b_v[1][7:0];
  assign if8.in_tag    = tag_v[1];
  assign if8.out_ready = ordy_v[1];
  assign ov_w[1]       = if8.out_valid;
  assign ir_w[1]       = if8.in_ready;
  assign mo_w[1]       = {48'd0, if8.mul_out};
  assign ot_w[1]       = if8.out_tag;

  assign if32.in_valid  = vld_v[2];
  assign if32.in_signed = sg_v[2];
  assign if32.mul_a     = a_v[2];
  assign if32.mul_b     = b_v[2];
  assign if32.in_tag    = tag_v[2];
  assign if32.out_ready = ordy_v[2];
  assign ov_w[2]        = if32.out_valid;
  assign ir_w[2]        = if32.in_ready;
  assign mo_w[2]        = if32.mul_out;
  assign ot_w[2]        = if32.out_tag;

  mul_pipe_param #(.WIDTH(4),  .TAG_W(4)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  mul_pipe_param #(.WIDTH(8),  .TAG_W(4)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  mul_pipe_param #(.WIDTH(32), .TAG_W(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

  typedef struct {
    int          dut;
    logic [63:0] prod;
    logic [3:0]  tag;
    int          acc;
    int          snap;
    logic        seen;
  } exp_t;

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   stalls [ND];
  int   rdone;

  function automatic int w_of(int d);
    case (d)
      0:       return 4;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int lat_of(int d);
    return 1 + $clog2(w_of(d));
  endfunction

  function automatic logic [31:0] wmask(int w);
    if (w == 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Reference: true product of the operands as integers, reduced to 2*w bits.
  function automatic logic [63:0] ref_mul(int w, logic [31:0] a, logic [31:0] b, logic sg);
    logic [63:0] ax, bx, mask, p;
    longint      sa, sb;
    ax = {32'd0, a};
    bx = {32'd0, b};
    if (w == 32) mask = ~64'd0;
    else         mask = (64'd1 << (2 * w)) - 64'd1;
    if (sg) begin
      sa = longint'(ax << (64 - w));
      sa = sa >>> (64 - w);
      sb = longint'(bx << (64 - w));
      sb = sb >>> (64 - w);
      p  = sa * sb;
    end else begin
      p = ax * bx;
    end
    return p & mask;
  endfunction

  function automatic int pending(int d);
    int n = 0;
    foreach (sb_q[i]) if (sb_q[i].dut == d) n++;
    return n;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Drive one operation and hold it until accepted; record the expectation.
  task automatic issue(int d, logic [31:0] a, logic [31:0] b, logic sg,
                       logic [3:0] tag, logic [63:0] exp);
    exp_t e;
    int   tries = 0;
    bit   done  = 1'b0;
    a_v[d] = a; b_v[d] = b; sg_v[d] = sg; tag_v[d] = tag; vld_v[d] = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ir_w[d]) begin
        e.dut = d; e.prod = exp; e.tag = tag; e.acc = cyc;
        e.snap = stalls[d]; e.seen = 1'b0;
        sb_q.push_back(e);
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 200) begin
          checks++; errors++;
          $display("FAIL accept_timeout dut=%0d in_ready stayed 0 for 200 cycles", d);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    vld_v[d] = 1'b0;
  endtask

  task automatic issue_rand(int d);
    logic [31:0] a, b;
    logic        sg;
    logic [3:0]  tg;
    a  = $urandom & wmask(w_of(d));
    b  = $urandom & wmask(w_of(d));
    sg = 1'($urandom_range(0, 1));
    tg = 4'($urandom_range(0, 15));
    issue(d, a, b, sg, tg, ref_mul(w_of(d), a, b, sg));
  endtask

  task automatic drain(int d);
    int n = 0;
    while (pending(d) > 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("drain_dut%0d_pending", d), 64'(pending(d)), 64'd0);
  endtask

  // Monitor: protocol check every cycle and scoreboard compare on each result.
  task automatic monitor();
    int idx;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < ND; d++) begin
          checks++;
          if (ir_w[d] !== (!ov_w[d] || ordy_v[d])) begin
            errors++;
            $display("FAIL in_ready dut=%0d got=%0b expected=%0b", d, ir_w[d], (!ov_w[d] || ordy_v[d]));
          end
          if (ov_w[d]) begin
            idx = -1;
            for (int i = 0; i < sb_q.size(); i++) begin
              if (sb_q[i].dut == d) begin
                idx = i;
                break;
              end
            end
            checks++;
            if (idx < 0) begin
              errors++;
              $display("FAIL unexpected_result dut=%0d got=%0h tag=%0h expected no result", d, mo_w[d], ot_w[d]);
            end else begin
              if (mo_w[d] !== sb_q[idx].prod || ot_w[d] !== sb_q[idx].tag) begin
                errors++;
                $display("FAIL result dut=%0d got=%0h tag=%0h expected=%0h tag=%0h",
                         d, mo_w[d], ot_w[d], sb_q[idx].prod, sb_q[idx].tag);
              end
              if (!sb_q[idx].seen) begin
                sb_q[idx].seen = 1'b1;
                if (sb_q[idx].snap == stalls[d]) begin
                  checks++;
                  if (cyc - sb_q[idx].acc != lat_of(d)) begin
                    errors++;
                    $display("FAIL latency dut=%0d got=%0d expected=%0d", d, cyc - sb_q[idx].acc, lat_of(d));
                  end
                end
              end
              if (ordy_v[d]) sb_q.delete(idx);
            end
            if (!ordy_v[d]) stalls[d]++;
          end
        end
      end
    end
  endtask

  initial begin
    int s0;
    bit got_ov;
    rst_n = 1'b0;
    rdone = 0;
    for (int d = 0; d < ND; d++) begin
      a_v[d] = 32'd0; b_v[d] = 32'd0; sg_v[d] = 1'b0; vld_v[d] = 1'b0;
      ordy_v[d] = 1'b1; tag_v[d] = 4'd0; stalls[d] = 0;
    end
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_out_valid_dut%0d", d), 64'(ov_w[d]), 64'd0);
      chk($sformatf("reset_mul_out_dut%0d", d),   mo_w[d],       64'd0);
      chk($sformatf("reset_out_tag_dut%0d", d),   64'(ot_w[d]), 64'd0);
      chk($sformatf("reset_in_ready_dut%0d", d),  64'(ir_w[d]), 64'd1);
    end
    rst_n = 1'b1;

    // Unsigned corners, back to back.
    issue(1, 32'd255, 32'd255, 1'b0, 4'd1, 64'h0000_FE01);
    issue(1, 32'd0,   32'd200, 1'b0, 4'd2, 64'h0000_0000);
    issue(1, 32'd1,   32'd173, 1'b0, 4'd3, 64'h0000_00AD);
    drain(1);

    // Signed corners.
    issue(1, 32'h80, 32'h80, 1'b1, 4'd4, 64'h0000_4000);
    issue(1, 32'hFF, 32'h7F, 1'b1, 4'd5, 64'h0000_FF81);
    issue(1, 32'h80, 32'h7F, 1'b1, 4'd6, 64'h0000_C080);
    issue(1, 32'h05, 32'hFD, 1'b1, 4'd7, 64'h0000_FFF1);
    drain(1);

    // Same operands, mode flips between consecutive operations.
    issue(1, 32'hFF, 32'hFF, 1'b0, 4'd8, 64'h0000_FE01);
    issue(1, 32'hFF, 32'hFF, 1'b1, 4'd9, 64'h0000_0001);
    drain(1);

    // Backpressure: 3-cycle stall once the first result shows up.
    s0 = stalls[1];
    got_ov = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) issue_rand(1);
      end
      begin
        for (int n = 0; n < 50; n++) begin
          @(posedge clk); #1;
          if (ov_w[1]) begin
            got_ov = 1'b1;
            break;
          end
        end
        if (got_ov) begin
          ordy_v[1] = 1'b0;
          repeat (3) begin
            @(posedge clk); #1;
          end
          ordy_v[1] = 1'b1;
        end
      end
    join
    chk("backpressure_out_valid_seen", 64'(got_ov), 64'd1);
    chk("backpressure_stall_cycles", 64'(stalls[1] - s0), 64'd3);
    drain(1);

    // Reset with three operations in flight.
    issue_rand(1);
    issue_rand(1);
    issue_rand(1);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(ov_w[1]), 64'd0);
    chk("midreset_mul_out",   mo_w[1],       64'd0);
    for (int i = sb_q.size() - 1; i >= 0; i--) sb_q.delete(i);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1, 32'd12, 32'd11, 1'b0, 4'hA, 64'd132);
    drain(1);
    repeat (10) @(posedge clk);
    #1;

    // Random sweep on the narrow and wide instances with random backpressure.
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          issue_rand(0);
        end
        rdone++;
      end
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          issue_rand(2);
        end
        rdone++;
      end
      begin
        while (rdone < 2) begin
          @(posedge clk); #1;
          ordy_v[0] = ($urandom_range(0, 3) != 0);
          ordy_v[2] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ordy_v[0] = 1'b1;
    ordy_v[2] = 1'b1;
    drain(0);
    drain(2);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_pipe_param.md
# mul_pipe_param

Parametrised, fully pipelined integer multiplier. It generalises the team's fixed 4-bit three-stage multiplier to any power-of-two operand width, adds per-transaction signed/unsigned mode, and adds a valid/ready handshake with whole-pipeline stall and a sideband tag. It sits in the arithmetic library as the drop-in multiplier for datapaths that need backpressure and in-order result tagging.

## Interface
- WIDTH, 8: operand width in bits. Must be a power of two, 4 to 32.
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept input this cycle.
- in_signed  in  1  1: operands are two's complement; 0: unsigned.
- mul_a  in  WIDTH  multiplicand.
- mul_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- out_valid  out  1  mul_out and out_tag hold a valid result.
- out_ready  in  1  downstream accepts the result this cycle.
- mul_out  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the result on mul_out.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv. This is combinational from out_ready and out_valid only, never from in_valid.
- Stage 0 (partial products): on adv, register WIDTH partial products, each 2*WIDTH bits.
  - Partial product i = (mul_a AND mul_b[i]) << i, extended to 2*WIDTH bits.
  - In signed mode, sign-extend mul_a. Partial product WIDTH-1 is negated (two's complement), because mul_b[WIDTH-1] carries weight -2^(WIDTH-1).
  - Also register the valid bit (in_valid && in_ready), the tag and the mode bit.
- Stages 1..log2(WIDTH) (reduction): each stage adds adjacent pairs from the previous stage, modulo 2^(2*WIDTH), and registers them on adv.
  - Each stage halves the operand count. Valid and tag move one stage per advance.
- The last reduction stage is the output register: mul_out, out_tag, out_valid.
- Arithmetic:
  - Unsigned: mul_out = a*b, exact, in 2*WIDTH bits.
  - Signed: mul_out = a*b as a 2*WIDTH-bit two's-complement value. It is exact for all inputs, including (-2^(WIDTH-1))^2.
- Stall behaviour:
  - When adv=0, every stage holds, including data, valid and tag.
  - No input is accepted while adv=0.
  - Bubbles (invalid stages) are not squeezed out.
- Ordering: results leave in input order, one per output transfer. No result is dropped or duplicated.
- Bubble contents: the data registers of an invalid stage may hold any value. mul_out and out_tag are don't-care while out_valid=0, except directly after reset.
- Reset (asserted at any time, including mid-stream or mid-stall):
  - All valid bits clear immediately (asynchronously).
  - All data, tag and output registers go to 0.
  - Results in flight are discarded.
- Reset values: out_valid=0, mul_out=0, out_tag=0. in_ready=1, because out_valid=0.

## Timing
- Latency L = 1 + log2(WIDTH) cycles from input transfer to out_valid, with no stall.
  - WIDTH=4: L=3. WIDTH=8: L=4. WIDTH=32: L=6.
- Throughput: one result per cycle while out_ready=1.
- Capacity: at most L operations in flight.
- Stall timing:
  - out_ready low with out_valid high freezes the pipeline in that same cycle.
  - The first cycle with out_ready high performs an output transfer and an input transfer together.
- Reset release: the first rising edge with rst_n=1 may accept an input.
- Critical path: one 2*WIDTH-bit adder per stage. Stage 0 must not use chained adders.

## Test plan
- Unsigned corners (WIDTH=8, in_signed=0):
  - Stimulus: 255*255, then 0*200, then 1*173, on consecutive cycles, out_ready=1.
  - Required: 0xFE01, 0x0000, 0x00AD on cycles 4, 5, 6 after the first transfer.
  - Required: tags returned in order.
- Signed corners (WIDTH=8, in_signed=1):
  - Stimulus: -128*-128, -1*127, -128*127, 5*-3.
  - Required: 0x4000, 0xFF81, 0xC080, 0xFFF1.
- Mixed mode back-to-back:
  - Stimulus: 0xFF*0xFF with in_signed=0, then the same operands with in_signed=1.
  - Required: 0xFE01, then 0x0001. A mode bit that leaks between stages fails this test.
- Backpressure:
  - Stimulus: stream 6 operations, and hold out_ready=0 for 3 cycles once out_valid first rises.
  - Required: mul_out and out_tag stable, and in_ready=0, throughout the stall.
  - Required: all 6 results appear in order, with none lost or duplicated.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 for 1 cycle with 3 operations in flight.
  - Required: out_valid=0 and mul_out=0 immediately. No stale result appears afterwards.
  - Required: the next input produces its result exactly L cycles after acceptance.
- Parameter sweep and random check:
  - Stimulus: WIDTH=4 and WIDTH=32, 10k random operands, random mode, random out_ready.
  - Required: scoreboard matches the reference product.
  - Required: latency is L=3 and L=6 respectively whenever there is no stall.
